// File: rtl/arm7tdmi_fill_responder_if.sv
// Line-fill burst bus between an instruction cache and its memory responder.
// Carries request (addr, beats-1, strobe, abort) and response (data, valid, ready).
interface arm7tdmi_fill_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_burst_len;
    logic                  abort;
    logic [31:0]           rsp_data;
    logic                  rsp_valid;
    logic                  rsp_ready;

    modport master (
        output req,
        output req_addr,
        output req_burst_len,
        output abort,
        input  rsp_data,
        input  rsp_valid,
        input  rsp_ready
    );

    modport slave (
        input  req,
        input  req_addr,
        input  req_burst_len,
        input  abort,
        output rsp_data,
        output rsp_valid,
        output rsp_ready
    );
endinterface

// File: rtl/arm7tdmi_fill_responder.sv
// Memory-side responder for I-cache line fills: one burst at a time, sequential
// words from an internal store with FIRST_WAIT / SEQ_WAIT wait states.
// Ports: clk, rst_n (async, active low); bus (slave: req/req_addr/req_burst_len/
// abort in, rsp_data/rsp_valid/rsp_ready out); load_we/load_addr/load_data
// preload port; busy; req_overrun (sticky); stat_bursts/stat_beats.
// Define ARM7TDMI_FILL_STATS_EN to build the statistics counters; otherwise
// the stat ports read as zero.
module arm7tdmi_fill_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int FIRST_WAIT      = 2,
    parameter int SEQ_WAIT        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    arm7tdmi_fill_responder_if.slave bus,
    input  logic                  load_we,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [31:0]           load_data,
    output logic                  busy,
    output logic                  req_overrun,
    output logic [31:0]           stat_bursts,
    output logic [31:0]           stat_beats
);
    localparam int IW = $clog2(MEM_DEPTH_WORDS);
    localparam logic [3:0] FW1 = 4'(FIRST_WAIT - 1);
    localparam logic [3:0] SW1 = 4'(SEQ_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        BEAT,
        GAP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nx;
    logic [3:0]    beats_left;
    logic [3:0]    beats_nx;
    logic [3:0]    wcnt;
    logic [3:0]    wcnt_nx;
    logic          in_beat;

    logic [31:0] mem [MEM_DEPTH_WORDS];

    // Only the word-index bits of either address are decoded.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr, load_addr};

    assign in_beat       = (state == BEAT);
    assign bus.rsp_ready = (state == IDLE);
    assign busy          = (state != IDLE);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        beats_nx = beats_left;
        wcnt_nx  = wcnt;
        unique case (state)
            IDLE: begin
                if (bus.req) begin
                    idx_nx   = bus.req_addr[IW+1:2];
                    beats_nx = {1'b0, bus.req_burst_len} + 4'd1;
                    if (FIRST_WAIT > 0) begin
                        state_nx = FIRST;
                        wcnt_nx  = FW1;
                    end else begin
                        state_nx = BEAT;
                    end
                end
            end
            FIRST: begin
                if (wcnt == 4'd0) state_nx = BEAT;
                else              wcnt_nx  = wcnt - 4'd1;
            end
            BEAT: begin
                idx_nx   = idx + 1'b1;
                beats_nx = beats_left - 4'd1;
                if (beats_left == 4'd1) begin
                    state_nx = IDLE;
                end else if (SEQ_WAIT > 0) begin
                    state_nx = GAP;
                    wcnt_nx  = SW1;
                end else begin
                    state_nx = BEAT;
                end
            end
            GAP: begin
                if (wcnt == 4'd0) state_nx = BEAT;
                else              wcnt_nx  = wcnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over everything, but the beat read this cycle still goes out.
        if (state != IDLE && bus.abort) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            beats_left    <= '0;
            wcnt          <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            req_overrun   <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            beats_left    <= beats_nx;
            wcnt          <= wcnt_nx;
            bus.rsp_valid <= in_beat;
            if (in_beat) bus.rsp_data <= mem[idx];
            if (bus.req && state != IDLE) req_overrun <= 1'b1;
        end
    end

    // Same-edge read above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_we) mem[load_addr[IW+1:2]] <= load_data;
    end

`ifdef ARM7TDMI_FILL_STATS_EN
    logic [31:0] n_bursts;
    logic [31:0] n_beats;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_bursts <= '0;
            n_beats  <= '0;
        end else if (in_beat) begin
            n_beats <= n_beats + 32'd1;
            if (beats_left == 4'd1) n_bursts <= n_bursts + 32'd1;
        end
    end

    assign stat_bursts = n_bursts;
    assign stat_beats  = n_beats;
`else
    assign stat_bursts = '0;
    assign stat_beats  = '0;
`endif
endmodule

// File: tb/tb_arm7tdmi_fill_responder.sv
// Bench for arm7tdmi_fill_responder: two instances (SEQ_WAIT=0/depth 4096 and
// SEQ_WAIT=1/depth 16) checked every cycle against a beat-schedule model.
module tb_arm7tdmi_fill_responder;
    localparam int N  = 2;
    localparam int FW = 2;

    int sw_m  [N] = '{0, 1};
    int dep_m [N] = '{4096, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req       [N];
    logic [31:0] req_addr  [N];
    logic [2:0]  len       [N];
    logic        abort     [N];
    logic        load_we   [N];
    logic [31:0] load_addr [N];
    logic [31:0] load_data [N];

    wire  [31:0] rsp_data  [N];
    wire         rsp_valid [N];
    wire         rsp_ready [N];
    wire         busy      [N];
    wire         ovr       [N];
    wire  [31:0] sb        [N];
    wire  [31:0] sbe       [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int SW  = (g == 0) ? 0 : 1;
        localparam int DEP = (g == 0) ? 4096 : 16;
        arm7tdmi_fill_responder_if #(.ADDR_WIDTH(32)) bus ();
        assign bus.req           = req[g];
        assign bus.req_addr      = req_addr[g];
        assign bus.req_burst_len = len[g];
        assign bus.abort         = abort[g];
        assign rsp_data[g]       = bus.rsp_data;
        assign rsp_valid[g]      = bus.rsp_valid;
        assign rsp_ready[g]      = bus.rsp_ready;
        arm7tdmi_fill_responder #(
            .ADDR_WIDTH(32),
            .MEM_DEPTH_WORDS(DEP),
            .FIRST_WAIT(FW),
            .SEQ_WAIT(SW)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus),
            .load_we(load_we[g]),
            .load_addr(load_addr[g]),
            .load_data(load_data[g]),
            .busy(busy[g]),
            .req_overrun(ovr[g]),
            .stat_bursts(sb[g]),
            .stat_beats(sbe[g])
        );
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h",
                     nm, i, cyc, act, exp);
        end
    endtask

    // Model: a burst is a schedule of beats at base + k*sp; abort truncates it.
    logic [31:0] mm [N][4096];
    int          idle_from [N];
    int          base      [N];
    int          sp        [N];
    int          nb        [N];
    int          kn        [N];
    int          len_req   [N];
    int          sidx      [N];
    logic [31:0] pend      [N];
    logic [31:0] data_m    [N];
    logic [31:0] beats_m   [N];
    logic [31:0] bursts_m  [N];
    bit          ovr_m     [N];

    int          nvis [N];
    int          logc [N][16];
    logic [31:0] logd [N][16];

    task automatic model_step(input int i);
        int t;
        int msk;
        int lim;
        int li;
        bit rdy;
        bit ev;
        t   = cyc;
        msk = dep_m[i] - 1;
        if (rst_n !== 1'b1) begin
            idle_from[i] = t;
            nb[i]        = 0;
            kn[i]        = 0;
            ovr_m[i]     = 1'b0;
            data_m[i]    = '0;
            beats_m[i]   = '0;
            bursts_m[i]  = '0;
        end
        rdy = (t >= idle_from[i]);
        ev  = (kn[i] < nb[i]) && (t == base[i] + kn[i] * sp[i]);
        if (ev) begin
            data_m[i] = pend[i];
            beats_m[i]++;
            if (kn[i] == len_req[i] - 1) bursts_m[i]++;
            kn[i]++;
        end
        chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(ev));
        chk("rsp_ready", i, 32'(rsp_ready[i]), 32'(rdy));
        chk("busy", i, 32'(busy[i]), 32'(!rdy));
        chk("rsp_data", i, rsp_data[i], data_m[i]);
        chk("req_overrun", i, 32'(ovr[i]), 32'(ovr_m[i]));
`ifdef ARM7TDMI_FILL_STATS_EN
        chk("stat_bursts", i, sb[i], bursts_m[i]);
        chk("stat_beats", i, sbe[i], beats_m[i]);
`else
        chk("stat_bursts", i, sb[i], 32'd0);
        chk("stat_beats", i, sbe[i], 32'd0);
`endif
        if (rsp_valid[i] === 1'b1) begin
            logc[i][nvis[i] % 16] = t;
            logd[i][nvis[i] % 16] = rsp_data[i];
            nvis[i]++;
        end
        if (rst_n === 1'b1) begin
            if (!rdy) begin
                if (req[i]) ovr_m[i] = 1'b1;
                if (abort[i]) begin
                    lim = (t + 1 >= base[i]) ? (t + 1 - base[i]) / sp[i] + 1 : 0;
                    if (lim < nb[i]) nb[i] = lim;
                    idle_from[i] = t + 1;
                end
            end else if (req[i]) begin
                base[i]      = t + FW + 2;
                sp[i]        = sw_m[i] + 1;
                nb[i]        = int'(len[i]) + 1;
                len_req[i]   = nb[i];
                kn[i]        = 0;
                sidx[i]      = int'(req_addr[i][31:2]) & msk;
                idle_from[i] = base[i] + (nb[i] - 1) * sp[i];
            end
            if (kn[i] < nb[i] && base[i] + kn[i] * sp[i] == t + 1)
                pend[i] = mm[i][(sidx[i] + kn[i]) & msk];
        end
        if (load_we[i]) begin
            li = int'(load_addr[i][31:2]) & msk;
            mm[i][li] = load_data[i];
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) model_step(i);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
        load_we[i]   = 1'b1;
        load_addr[i] = a;
        load_data[i] = d;
        step(1);
        load_we[i]   = 1'b0;
    endtask

    task automatic burst(input int i, input logic [31:0] a,
                         input logic [2:0] l, output int t0);
        nvis[i]     = 0;
        req[i]      = 1'b1;
        req_addr[i] = a;
        len[i]      = l;
        t0          = cyc;
        step(1);
        req[i]      = 1'b0;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] !== 1'b0 && n < 200) begin
            step(1);
            n++;
        end
        chk("idle_timeout", i, 32'(n < 200), 32'd1);
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int t0;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = 0; req_addr[i] = 0; len[i] = 0; abort[i] = 0;
            load_we[i] = 0; load_addr[i] = 0; load_data[i] = 0;
            nvis[i] = 0; base[i] = 0; sp[i] = 1; nb[i] = 0; kn[i] = 0;
            len_req[i] = 0; sidx[i] = 0; pend[i] = 0; idle_from[i] = 0;
        end
        step(3);
        chk("rst_ready_lit", 0, 32'(rsp_ready[0]), 32'd1);
        chk("rst_data_lit", 1, rsp_data[1], 32'd0);
        rst_n = 1'b1;
        step(1);

        for (int k = 0; k < 8; k++) load(0, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
        for (int k = 0; k < 16; k++) load(1, 32'(4 * k), 32'hA0 + 32'(k));

        // 8-beat line, back-to-back beats
        burst(0, 32'h100, 3'd7, t0);
        wait_idle(0);
        chk("l1_nbeats", 0, nvis[0], 8);
        chk("l1_first", 0, logc[0][0], t0 + 4);
        chk("l1_last", 0, logc[0][7], t0 + 11);
        for (int k = 0; k < 8; k++) chk("l1_data", 0, logd[0][k], 32'hA0 + 32'(k));
        chk("l1_hold", 0, rsp_data[0], 32'hA7);
`ifdef ARM7TDMI_FILL_STATS_EN
        chk("l1_bursts_lit", 0, sb[0], 32'd1);
        chk("l1_beats_lit", 0, sbe[0], 32'd8);
`endif

        // two beats spaced by one wait cycle
        burst(1, 32'h104, 3'd1, t0);
        wait_idle(1);
        chk("sw_nbeats", 1, nvis[1], 2);
        chk("sw_d0", 1, logd[1][0], 32'hA1);
        chk("sw_d1", 1, logd[1][1], 32'hA2);
        chk("sw_space", 1, logc[1][1] - logc[1][0], 2);

        // wrap at end of a 16-word store
        burst(1, 32'h3C, 3'd2, t0);
        wait_idle(1);
        chk("wr_d0", 1, logd[1][0], 32'hAF);
        chk("wr_d1", 1, logd[1][1], 32'hA0);
        chk("wr_d2", 1, logd[1][2], 32'hA1);

        // req held during busy: one burst, sticky overrun
        nvis[0]     = 0;
        req[0]      = 1'b1;
        req_addr[0] = 32'h110;
        len[0]      = 3'd1;
        step(4);
        req[0]      = 1'b0;
        wait_idle(0);
        step(5);
        chk("ov_nbeats", 0, nvis[0], 2);
        chk("ov_d0", 0, logd[0][0], 32'hA4);
        chk("ov_sticky", 0, 32'(ovr[0]), 32'd1);

        // load write colliding with the beat read of word 2
        burst(0, 32'h100, 3'd7, t0);
        step(4);
        load(0, 32'h108, 32'hDEAD);
        wait_idle(0);
        chk("col_old", 0, logd[0][2], 32'hA2);
        chk("col_next", 0, logd[0][3], 32'hA3);
        burst(0, 32'h108, 3'd0, t0);
        wait_idle(0);
        chk("col_new", 0, logd[0][0], 32'hDEAD);

        // reset mid-burst
        burst(1, 32'h0, 3'd7, t0);
        step(4);
        rst_n = 1'b0;
        step(1);
        chk("rst_busy", 1, 32'(busy[1]), 32'd0);
        rst_n = 1'b1;
        nvis[1] = 0;
        step(12);
        chk("rst_nobeat", 1, nvis[1], 0);
        chk("rst_ovr_clr", 0, 32'(ovr[0]), 32'd0);

        // abort in the gap after the third beat
        burst(1, 32'h0, 3'd7, t0);
        step(7);
        abort[1] = 1'b1;
        step(1);
        abort[1] = 1'b0;
        chk("ab_ready", 1, 32'(rsp_ready[1]), 32'd1);
        step(10);
        chk("ab_nbeats", 1, nvis[1], 3);
`ifdef ARM7TDMI_FILL_STATS_EN
        chk("ab_bursts_lit", 1, sb[1], 32'd0);
        chk("ab_beats_lit", 1, sbe[1], 32'd3);
`endif

        // abort ignored in IDLE; abort beats req while busy
        abort[0] = 1'b1;
        burst(0, 32'h104, 3'd0, t0);
        abort[0] = 1'b0;
        wait_idle(0);
        chk("ai_nbeats", 0, nvis[0], 1);
        chk("ai_d0", 0, logd[0][0], 32'hA1);
        burst(0, 32'h100, 3'd3, t0);
        req[0]   = 1'b1;
        abort[0] = 1'b1;
        step(1);
        req[0]   = 1'b0;
        abort[0] = 1'b0;
        step(8);
        chk("ap_nbeats", 0, nvis[0], 0);
        chk("ap_ovr", 0, 32'(ovr[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
